// File: rtl/chess_clock_pkg.sv
// Shared chess-clock definitions: FSM encoding, BCD digit width, limits and default times
// reused by both player countdown instances.
package chess_clock_pkg;

    localparam int unsigned DIGIT_W      = 4;
    localparam int unsigned MAX_MIN      = 99;
    localparam int unsigned SEC_TENS_MAX = 5;

    localparam int unsigned DEF_INIT_MIN = 5;
    localparam int unsigned DEF_INIT_SEC = 0;
    localparam int unsigned DEF_INC_SEC  = 0;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StExpired
    } state_e;

    function automatic logic [DIGIT_W-1:0] bcd_tens(int unsigned v);
        return DIGIT_W'(v / 10);
    endfunction

    function automatic logic [DIGIT_W-1:0] bcd_units(int unsigned v);
        return DIGIT_W'(v % 10);
    endfunction

endpackage

// File: rtl/player_countdown_timer_if.sv
// Control inputs and BCD time / flag outputs of one player's countdown timer.
interface player_countdown_timer_if;

    logic                                ce;
    logic                                active;
    logic                                move_done;
    logic                                load;
    logic [chess_clock_pkg::DIGIT_W-1:0] min_t;
    logic [chess_clock_pkg::DIGIT_W-1:0] min_u;
    logic [chess_clock_pkg::DIGIT_W-1:0] sec_t;
    logic [chess_clock_pkg::DIGIT_W-1:0] sec_u;
    logic                                overflow;

    modport master (
        output ce, active, move_done, load,
        input  min_t, min_u, sec_t, sec_u, overflow
    );

    modport slave (
        input  ce, active, move_done, load,
        output min_t, min_u, sec_t, sec_u, overflow
    );

endinterface

// File: rtl/player_countdown_timer_bcd_digit.sv
// Mod-N BCD digit: load, decrement with borrow-out, and add with carry-in/carry-out.
module bcd_digit
    import chess_clock_pkg::*;
#(
    parameter int unsigned N = 10
) (
    input  logic               clk,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               dec,
    input  logic               add,
    input  logic [DIGIT_W-1:0] add_val,
    input  logic               carry_in,
    output logic [DIGIT_W-1:0] q,
    output logic               borrow_out,
    output logic               carry_out
);

    localparam logic [DIGIT_W-1:0] TopVal = DIGIT_W'(N - 1);
    localparam logic [DIGIT_W:0]   ModVal = (DIGIT_W + 1)'(N);

    logic [DIGIT_W-1:0] q_q, q_d;
    logic [DIGIT_W:0]   sum;

    always_comb begin
        sum        = {1'b0, q_q} + {1'b0, add_val} + {{DIGIT_W{1'b0}}, carry_in};
        carry_out  = (sum >= ModVal);
        borrow_out = dec && (q_q == '0);
        q_d        = q_q;
        if (load) begin
            q_d = load_val;
        end else if (dec) begin
            q_d = (q_q == '0) ? TopVal : q_q - 1'b1;
        end else if (add) begin
            q_d = carry_out ? DIGIT_W'(sum - ModVal) : sum[DIGIT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/player_countdown_timer.sv
// One player's MM:SS BCD countdown with Fischer increment, saturation at 99:59 and flag fall.
module player_countdown_timer
    import chess_clock_pkg::*;
#(
    parameter int unsigned INIT_MIN = DEF_INIT_MIN,
    parameter int unsigned INIT_SEC = DEF_INIT_SEC,
    parameter int unsigned INC_SEC  = DEF_INC_SEC
) (
    input logic                   clk,
    input logic                   clr,
    player_countdown_timer_if.slave bus
);

    state_e state_q, state_d;
    logic   pend_q, pend_d;
    logic   hold_q, hold_d;
    logic   ovf_q, ovf_d;

    logic reload, do_dec, do_add, sat, ce_eff, time_zero, digit_load;
    logic [DIGIT_W-1:0] q_mt, q_mu, q_st, q_su;
    logic [DIGIT_W-1:0] ld_mt, ld_mu, ld_st, ld_su;
    logic b_su, b_st, b_mu, unused_b_mt;
    logic c_su, c_st, c_mu, c_mt;

    assign reload     = clr | bus.load;
    assign time_zero  = (q_mt == '0) && (q_mu == '0) && (q_st == '0) && (q_su == '0);
    assign ce_eff     = bus.ce | hold_q;
    assign sat        = do_add & c_mt;
    assign digit_load = reload | sat;

    // Saturation reuses the load path with 99:59; reload always wins.
    assign ld_mt = reload ? bcd_tens(INIT_MIN)  : bcd_tens(MAX_MIN);
    assign ld_mu = reload ? bcd_units(INIT_MIN) : bcd_units(MAX_MIN);
    assign ld_st = reload ? bcd_tens(INIT_SEC)  : DIGIT_W'(SEC_TENS_MAX);
    assign ld_su = reload ? bcd_units(INIT_SEC) : DIGIT_W'(9);

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        hold_d  = 1'b0;
        ovf_d   = ovf_q;
        do_dec  = 1'b0;
        do_add  = 1'b0;
        // A pending add takes this cycle; a coincident CE is deferred by one cycle.
        if (pend_q) begin
            do_add = 1'b1;
            pend_d = 1'b0;
            hold_d = bus.ce && (state_q == StRun);
        end
        unique case (state_q)
            StIdle: begin
                if (bus.active) state_d = StRun;
            end
            StRun: begin
                if (!pend_q) begin
                    if (ce_eff && time_zero) begin
                        state_d = StExpired;
                        ovf_d   = 1'b1;
                        pend_d  = 1'b0;
                    end else if (ce_eff) begin
                        do_dec = 1'b1;
                        pend_d = bus.move_done;
                    end else if (bus.move_done) begin
                        do_add = 1'b1;
                    end
                end
                if (!bus.active && state_d != StExpired) state_d = StIdle;
            end
            StExpired: begin
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reload) begin
            state_q <= StIdle;
            pend_q  <= 1'b0;
            hold_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            hold_q  <= hold_d;
            ovf_q   <= ovf_d;
        end
    end

    bcd_digit #(.N(10)) u_sec_u (
        .clk(clk), .load(digit_load), .load_val(ld_su), .dec(do_dec), .add(do_add),
        .add_val(bcd_units(INC_SEC)), .carry_in(1'b0), .q(q_su), .borrow_out(b_su),
        .carry_out(c_su)
    );

    bcd_digit #(.N(SEC_TENS_MAX + 1)) u_sec_t (
        .clk(clk), .load(digit_load), .load_val(ld_st), .dec(b_su), .add(do_add),
        .add_val(bcd_tens(INC_SEC)), .carry_in(c_su), .q(q_st), .borrow_out(b_st),
        .carry_out(c_st)
    );

    bcd_digit #(.N(10)) u_min_u (
        .clk(clk), .load(digit_load), .load_val(ld_mu), .dec(b_st), .add(do_add),
        .add_val('0), .carry_in(c_st), .q(q_mu), .borrow_out(b_mu), .carry_out(c_mu)
    );

    bcd_digit #(.N(10)) u_min_t (
        .clk(clk), .load(digit_load), .load_val(ld_mt), .dec(b_mu), .add(do_add),
        .add_val('0), .carry_in(c_mu), .q(q_mt), .borrow_out(unused_b_mt), .carry_out(c_mt)
    );

    assign bus.min_t    = q_mt;
    assign bus.min_u    = q_mu;
    assign bus.sec_t    = q_st;
    assign bus.sec_u    = q_su;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_player_countdown_timer.sv
// Directed bench for player_countdown_timer across several INIT/INC configurations.
module tb_player_countdown_timer;

    logic clk;
    logic clr;
    int   errors;
    int   checks;

    player_countdown_timer_if if_a ();
    player_countdown_timer_if if_b ();
    player_countdown_timer_if if_c ();
    player_countdown_timer_if if_d ();
    player_countdown_timer_if if_e ();

    player_countdown_timer #(.INIT_MIN(5), .INIT_SEC(0), .INC_SEC(0))
        dut_a (.clk(clk), .clr(clr), .bus(if_a));
    player_countdown_timer #(.INIT_MIN(0), .INIT_SEC(2), .INC_SEC(0))
        dut_b (.clk(clk), .clr(clr), .bus(if_b));
    player_countdown_timer #(.INIT_MIN(5), .INIT_SEC(0), .INC_SEC(5))
        dut_c (.clk(clk), .clr(clr), .bus(if_c));
    player_countdown_timer #(.INIT_MIN(99), .INIT_SEC(58), .INC_SEC(5))
        dut_d (.clk(clk), .clr(clr), .bus(if_d));
    player_countdown_timer #(.INIT_MIN(10), .INIT_SEC(0), .INC_SEC(0))
        dut_e (.clk(clk), .clr(clr), .bus(if_e));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clr    = 1'b0;
        {if_a.ce, if_a.active, if_a.move_done, if_a.load} = '0;
        {if_b.ce, if_b.active, if_b.move_done, if_b.load} = '0;
        {if_c.ce, if_c.active, if_c.move_done, if_c.load} = '0;
        {if_d.ce, if_d.active, if_d.move_done, if_d.load} = '0;
        {if_e.ce, if_e.active, if_e.move_done, if_e.load} = '0;

        clr = 1'b1; step(); clr = 1'b0;
        check_eq("reset_time", {if_a.min_t, if_a.min_u, if_a.sec_t, if_a.sec_u}, 32'h0500);
        check_eq("reset_ovf", 32'(if_a.overflow), 32'h0);
        if_a.ce = 1'b1; step(); if_a.ce = 1'b0; step();
        check_eq("idle_ce_ignored", {if_a.min_t, if_a.min_u, if_a.sec_t, if_a.sec_u}, 32'h0500);

        if_a.active = 1'b1; step();
        if_a.ce = 1'b1; step(); if_a.ce = 1'b0;
        check_eq("dec_0500", {if_a.min_t, if_a.min_u, if_a.sec_t, if_a.sec_u}, 32'h0459);
        if_a.ce = 1'b1;
        repeat (239) step();
        if_a.ce = 1'b0;
        check_eq("dec_to_0100", {if_a.min_t, if_a.min_u, if_a.sec_t, if_a.sec_u}, 32'h0100);
        if_a.ce = 1'b1; step(); if_a.ce = 1'b0;
        check_eq("dec_0100", {if_a.min_t, if_a.min_u, if_a.sec_t, if_a.sec_u}, 32'h0059);

        if_e.active = 1'b1; step();
        if_e.ce = 1'b1; step(); if_e.ce = 1'b0;
        check_eq("dec_1000", {if_e.min_t, if_e.min_u, if_e.sec_t, if_e.sec_u}, 32'h0959);

        if_b.active = 1'b1; step();
        if_b.ce = 1'b1; step();
        check_eq("exp_0001", {if_b.min_t, if_b.min_u, if_b.sec_t, if_b.sec_u}, 32'h0001);
        step();
        check_eq("exp_0000", {if_b.min_t, if_b.min_u, if_b.sec_t, if_b.sec_u}, 32'h0000);
        check_eq("exp_ovf_not_yet", 32'(if_b.overflow), 32'h0);
        step();
        check_eq("exp_ovf_set", 32'(if_b.overflow), 32'h1);
        check_eq("exp_hold_zero", {if_b.min_t, if_b.min_u, if_b.sec_t, if_b.sec_u}, 32'h0000);
        step(); if_b.ce = 1'b0;
        check_eq("exp_4th_time", {if_b.min_t, if_b.min_u, if_b.sec_t, if_b.sec_u}, 32'h0000);
        check_eq("exp_4th_ovf", 32'(if_b.overflow), 32'h1);

        if_c.active = 1'b1; step();
        if_c.ce = 1'b1; repeat (3) step(); if_c.ce = 1'b0;
        check_eq("inc_pre", {if_c.min_t, if_c.min_u, if_c.sec_t, if_c.sec_u}, 32'h0457);
        if_c.move_done = 1'b1; step(); if_c.move_done = 1'b0;
        check_eq("inc_alone", {if_c.min_t, if_c.min_u, if_c.sec_t, if_c.sec_u}, 32'h0502);
        if_c.load = 1'b1; step(); if_c.load = 1'b0;
        check_eq("inc_reload", {if_c.min_t, if_c.min_u, if_c.sec_t, if_c.sec_u}, 32'h0500);
        step();
        if_c.ce = 1'b1; repeat (3) step();
        if_c.move_done = 1'b1; step(); if_c.ce = 1'b0; if_c.move_done = 1'b0;
        check_eq("pend_dec", {if_c.min_t, if_c.min_u, if_c.sec_t, if_c.sec_u}, 32'h0456);
        step();
        check_eq("pend_add", {if_c.min_t, if_c.min_u, if_c.sec_t, if_c.sec_u}, 32'h0501);
        if_c.ce = 1'b1; if_c.move_done = 1'b1; step(); if_c.move_done = 1'b0;
        check_eq("held_dec1", {if_c.min_t, if_c.min_u, if_c.sec_t, if_c.sec_u}, 32'h0500);
        step(); if_c.ce = 1'b0;
        check_eq("held_add", {if_c.min_t, if_c.min_u, if_c.sec_t, if_c.sec_u}, 32'h0505);
        step();
        check_eq("held_ce_kept", {if_c.min_t, if_c.min_u, if_c.sec_t, if_c.sec_u}, 32'h0504);

        if_d.active = 1'b1; step();
        if_d.move_done = 1'b1; step(); if_d.move_done = 1'b0;
        check_eq("sat_9959", {if_d.min_t, if_d.min_u, if_d.sec_t, if_d.sec_u}, 32'h9959);
        if_d.ce = 1'b1; step(); if_d.ce = 1'b0;
        check_eq("sat_dec", {if_d.min_t, if_d.min_u, if_d.sec_t, if_d.sec_u}, 32'h9958);

        if_b.active = 1'b0; step();
        if_b.load = 1'b1; step(); if_b.load = 1'b0;
        check_eq("load_time", {if_b.min_t, if_b.min_u, if_b.sec_t, if_b.sec_u}, 32'h0002);
        check_eq("load_ovf", 32'(if_b.overflow), 32'h0);
        if_b.ce = 1'b1; step(); if_b.ce = 1'b0; step();
        check_eq("load_idle", {if_b.min_t, if_b.min_u, if_b.sec_t, if_b.sec_u}, 32'h0002);

        if_c.ce = 1'b1; if_c.move_done = 1'b1; step();
        if_c.ce = 1'b0; if_c.move_done = 1'b0;
        check_eq("clr_pend_pre", {if_c.min_t, if_c.min_u, if_c.sec_t, if_c.sec_u}, 32'h0503);
        clr = 1'b1; if_c.active = 1'b0; step(); clr = 1'b0;
        check_eq("clr_pend_time", {if_c.min_t, if_c.min_u, if_c.sec_t, if_c.sec_u}, 32'h0500);
        step();
        check_eq("clr_pend_no_add", {if_c.min_t, if_c.min_u, if_c.sec_t, if_c.sec_u}, 32'h0500);
        check_eq("clr_pend_ovf", 32'(if_c.overflow), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
